// File: rtl/decode_queue.sv
// decode_queue: RV32I field/immediate decoder feeding an in-order FIFO of decoded bundles.
// Decoding happens on the incoming instruction, and the full bundle is stored at push.
// Outputs always show the head entry and read as zero while the queue is empty.
module decode_queue #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DWIDTH-1:0]          insn_i,
    input  logic [AWIDTH-1:0]          pc_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [AWIDTH-1:0]          pc_o,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [6:0]                 opcode_o,
    output logic [4:0]                 rd_o,
    output logic [4:0]                 rs1_o,
    output logic [4:0]                 rs2_o,
    output logic [2:0]                 funct3_o,
    output logic [6:0]                 funct7_o,
    output logic [4:0]                 shamt_o,
    output logic [DWIDTH-1:0]          imm_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    // A one-entry queue still gets a 1-bit pointer; it simply never leaves 0.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        shamt;
        logic [DWIDTH-1:0] imm;
        logic              illegal;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;
    logic [31:0]     ins;
    logic [31:0]     imm32;
    logic            ill;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ins         = insn_i[31:0];
    assign in_ready_o  = (count_q != CW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;
    assign count_o     = count_q;

    // Decode the incoming instruction into a bundle; unused fields are zeroed per format.
    always_comb begin
        dec        = '0;
        imm32      = '0;
        ill        = 1'b0;
        dec.pc     = pc_i;
        dec.insn   = insn_i;
        dec.opcode = ins[6:0];
        dec.rd     = ins[11:7];
        dec.rs1    = ins[19:15];
        dec.funct3 = ins[14:12];
        case (ins[6:0])
            OpLui, OpAuipc: begin
                imm32      = {ins[31:12], 12'b0};
                dec.rs1    = '0;
                dec.funct3 = '0;
            end
            OpJal: begin
                imm32      = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                dec.rs1    = '0;
                dec.funct3 = '0;
            end
            OpJalr: begin
                imm32 = {{20{ins[31]}}, ins[31:20]};
                ill   = (ins[14:12] != 3'b000);
            end
            OpBranch: begin
                imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                dec.rd  = '0;
                dec.rs2 = ins[24:20];
                ill     = (ins[14:13] == 2'b01);
            end
            OpLoad: begin
                imm32 = {{20{ins[31]}}, ins[31:20]};
                ill   = (ins[14:12] == 3'b011) || (ins[14:13] == 2'b11);
            end
            OpStore: begin
                imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec.rd  = '0;
                dec.rs2 = ins[24:20];
                ill     = (ins[14:12] > 3'b010);
            end
            OpOpImm: begin
                imm32 = {{20{ins[31]}}, ins[31:20]};
                if (ins[14:12] == 3'b001) begin
                    dec.funct7 = ins[31:25];
                    dec.shamt  = ins[24:20];
                    ill        = (ins[31:25] != 7'b0000000);
                end else if (ins[14:12] == 3'b101) begin
                    dec.funct7 = ins[31:25];
                    dec.shamt  = ins[24:20];
                    ill        = (ins[31:25] != 7'b0000000) && (ins[31:25] != 7'b0100000);
                end
            end
            OpOp: begin
                dec.rs2    = ins[24:20];
                dec.funct7 = ins[31:25];
                // Only ADD/SUB and SRL/SRA have an alternate (0100000) encoding.
                ill = !((ins[31:25] == 7'b0000000) ||
                        ((ins[31:25] == 7'b0100000) &&
                         ((ins[14:12] == 3'b000) || (ins[14:12] == 3'b101))));
            end
            OpMiscMem, OpSystem: begin
            end
            default: ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) begin
            ill = 1'b1;
        end
        dec.imm     = DWIDTH'(imm32);
        dec.illegal = ill;
    end

    // Storage needs no reset: empty slots are never visible on the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= dec;
        end
    end

    // Pointer and occupancy bookkeeping; flush outranks any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Present the head entry, forced to zero while the queue is empty.
    always_comb begin
        head = out_valid_o ? mem[rd_ptr_q] : '0;
    end

    assign pc_o      = head.pc;
    assign insn_o    = head.insn;
    assign opcode_o  = head.opcode;
    assign rd_o      = head.rd;
    assign rs1_o     = head.rs1;
    assign rs2_o     = head.rs2;
    assign funct3_o  = head.funct3;
    assign funct7_o  = head.funct7;
    assign shamt_o   = head.shamt;
    assign imm_o     = head.imm;
    assign illegal_o = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue (DEPTH=2).
// Expected bundles are queued as each push is accepted and compared when the head pops.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] insn_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  shamt_o;
    logic [31:0] imm_o;
    logic        illegal_o;
    logic [1:0]  count_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [4:0]  shamt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    decode_queue #(
        .DWIDTH(32),
        .AWIDTH(32),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .insn_i     (insn_i),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .pc_o       (pc_o),
        .insn_o     (insn_o),
        .opcode_o   (opcode_o),
        .rd_o       (rd_o),
        .rs1_o      (rs1_o),
        .rs2_o      (rs2_o),
        .funct3_o   (funct3_o),
        .funct7_o   (funct7_o),
        .shamt_o    (shamt_o),
        .imm_o      (imm_o),
        .illegal_o  (illegal_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] insn,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [6:0] f7, input logic [4:0] shamt,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.insn = insn; e.imm = imm; e.rd = rd; e.rs1 = rs1;
        e.rs2 = rs2; e.f7 = f7; e.shamt = shamt; e.ill = ill;
        return e;
    endfunction

    // ADDI x1, x0, k
    function automatic exp_t fill(input logic [31:0] pc, input logic [10:0] k);
        return mk(pc, ({21'd0, k} << 20) | 32'h0000_0093, {21'd0, k}, 5'd1, 5'd0, 5'd0,
                  7'd0, 5'd0, 1'b0);
    endfunction

    task automatic compare_head(input exp_t e);
        check_eq("pc", pc_o, e.pc);
        check_eq("insn", insn_o, e.insn);
        check_eq("opcode", 32'(opcode_o), 32'(e.insn[6:0]));
        check_eq("imm", imm_o, e.imm);
        check_eq("rd", 32'(rd_o), 32'(e.rd));
        check_eq("rs1", 32'(rs1_o), 32'(e.rs1));
        check_eq("rs2", 32'(rs2_o), 32'(e.rs2));
        check_eq("funct7", 32'(funct7_o), 32'(e.f7));
        check_eq("shamt", 32'(shamt_o), 32'(e.shamt));
        check_eq("illegal", 32'(illegal_o), 32'(e.ill));
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, then book the upcoming edge.
    task automatic cycle(input logic v, input exp_t e, input logic ordy, input logic fl,
                         output logic acc);
        @(negedge clk);
        in_valid_i  = v;
        insn_i      = e.insn;
        pc_i        = e.pc;
        out_ready_i = ordy;
        flush_i     = fl;
        #1;
        acc = 1'b0;
        check_eq("count", 32'(count_o), 32'(sb.size()));
        check_eq("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
        check_eq("in_ready", 32'(in_ready_o), 32'(sb.size() != 2));
        if (!out_valid_o) begin
            check_eq("empty_pc_zero", pc_o, 32'h0);
            check_eq("empty_imm_zero", imm_o, 32'h0);
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (out_valid_o && ordy && sb.size() != 0) begin
                compare_head(sb.pop_front());
            end
            if (v && in_ready_o) begin
                sb.push_back(e);
                acc = 1'b1;
            end
        end
    endtask

    task automatic push(input exp_t e, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            cycle(1'b1, e, ordy, 1'b0, acc);
        end
        if (!acc) check_eq("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic acc;
        exp_t nop;
        nop = mk(32'h0, 32'h13, 32'h0, 5'd0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        for (int i = 0; i < 20 && (sb.size() != 0 || out_valid_o); i++) begin
            cycle(1'b0, nop, 1'b1, 1'b0, acc);
        end
        cycle(1'b0, nop, 1'b1, 1'b0, acc);
        check_eq("drained", 32'(sb.size()), 32'd0);
    endtask

    exp_t vec[$];
    exp_t nop_e;
    logic acc_o;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; insn_i = '0; pc_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        nop_e = mk(32'h0, 32'h13, 32'h0, 5'd0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        #2;
        check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready_o), 32'd1);
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Decode values and illegal-instruction flags.
        vec.push_back(mk(32'h1000, 32'h123452B7, 32'h12345000, 5'd5, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0));
        vec.push_back(mk(32'h1004, 32'hFFC48413, 32'hFFFFFFFC, 5'd8, 5'd9, 5'd0, 7'd0, 5'd0, 1'b0));
        vec.push_back(mk(32'h1008, 32'h0036D613, 32'h00000003, 5'd12, 5'd13, 5'd0, 7'd0, 5'd3, 1'b0));
        vec.push_back(mk(32'h100C, 32'h00418463, 32'h00000008, 5'd0, 5'd3, 5'd4, 7'd0, 5'd0, 1'b0));
        vec.push_back(mk(32'h1010, 32'h801FF0EF, 32'hFFFFF800, 5'd1, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0));
        vec.push_back(mk(32'h1014, 32'h00B0AA23, 32'h00000014, 5'd0, 5'd1, 5'd11, 7'd0, 5'd0, 1'b0));
        vec.push_back(mk(32'h1018, 32'h403100B3, 32'h00000000, 5'd1, 5'd2, 5'd3, 7'h20, 5'd0, 1'b0));
        vec.push_back(mk(32'h101C, 32'hFFFFFFFF, 32'h00000000, 5'd31, 5'd31, 5'd0, 7'd0, 5'd0, 1'b1));
        vec.push_back(mk(32'h1020, 32'h000110E7, 32'h00000000, 5'd1, 5'd2, 5'd0, 7'd0, 5'd0, 1'b1));
        vec.push_back(mk(32'h1024, 32'h40219213, 32'h00000402, 5'd4, 5'd3, 5'd0, 7'h20, 5'd2, 1'b1));
        vec.push_back(mk(32'h1028, 32'h00000013, 32'h00000000, 5'd0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0));
        foreach (vec[i]) push(vec[i], 1'b1);
        drain();

        // Backpressure: third push must wait until the full queue pops.
        push(fill(32'h20000004, 11'd1), 1'b0);
        push(fill(32'h20000008, 11'd2), 1'b0);
        cycle(1'b1, fill(32'h2000000C, 11'd3), 1'b0, 1'b0, acc_o);
        check_eq("full_no_accept", 32'(acc_o), 32'd0);
        check_eq("full_count", 32'(count_o), 32'd2);
        check_eq("full_in_ready", 32'(in_ready_o), 32'd0);
        push(fill(32'h2000000C, 11'd3), 1'b1);
        drain();

        // Simultaneous push/pop at occupancy 1; pointers wrap several times.
        push(fill(32'h30000000, 11'd10), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            push(fill(32'h30000000 + 32'(i * 4), 11'(10 + i)), 1'b1);
            check_eq("steady_count", 32'(count_o), 32'd1);
        end
        drain();

        // Flush while full with a push offered.
        push(fill(32'h40000000, 11'd20), 1'b0);
        push(fill(32'h40000004, 11'd21), 1'b0);
        cycle(1'b1, fill(32'h40000008, 11'd22), 1'b0, 1'b1, acc_o);
        cycle(1'b0, nop_e, 1'b0, 1'b0, acc_o);
        check_eq("flush_count", 32'(count_o), 32'd0);
        check_eq("flush_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("flush_in_ready", 32'(in_ready_o), 32'd1);

        // Flush at occupancy 1 with push and pop both offered: neither takes effect.
        push(fill(32'h50000000, 11'd30), 1'b0);
        cycle(1'b1, fill(32'h50000004, 11'd31), 1'b1, 1'b1, acc_o);
        cycle(1'b0, nop_e, 1'b0, 1'b0, acc_o);
        check_eq("flush2_count", 32'(count_o), 32'd0);
        push(fill(32'h50000008, 11'd32), 1'b1);
        drain();

        // Asynchronous reset between edges clears the queue immediately.
        push(fill(32'h60000000, 11'd40), 1'b0);
        push(fill(32'h60000004, 11'd41), 1'b0);
        @(negedge clk);
        in_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("arst_count", 32'(count_o), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready_o), 32'd1);
        check_eq("arst_pc", pc_o, 32'h0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        push(fill(32'h70000000, 11'd50), 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
